// File: rtl/cubic_pkg.sv
// Shared types and Q16.16 constants for the cubic pipeline frame reducer.
package cubic_pkg;

  typedef enum logic {
    ACCUM,
    EMIT
  } state_t;

  // Order of the four summary beats sent for each frame.
  typedef enum logic [1:0] {
    CNT,
    MIN,
    MAX,
    SUM
  } beat_t;

  localparam int          Q_FRAC = 16;
  localparam logic [31:0] Q_ONE  = 32'h0001_0000;

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI4-Stream bundle (TDATA/TVALID/TREADY/TLAST).
interface axi_stream_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/frame_stats_acc.sv
// Per-frame count/min/max/sum registers; the sum is a saturating
// DATA_W+CNT_W accumulator, narrowed with saturation for output.
module frame_stats_acc
  import cubic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     first,
  input  logic                     update,
  input  logic signed [DATA_W-1:0] data,
  output logic        [CNT_W-1:0]  count,
  output logic signed [DATA_W-1:0] min_v,
  output logic signed [DATA_W-1:0] max_v,
  output logic signed [DATA_W-1:0] sum_sat
);

  localparam int SUM_W = DATA_W + CNT_W;

  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] data_ext;
  logic signed [SUM_W:0]   sum_wide;
  logic signed [SUM_W-1:0] sum_next;
  logic [CNT_W:0]          sum_top;

  assign data_ext = {{CNT_W{data[DATA_W-1]}}, data};
  assign sum_wide = {sum[SUM_W-1], sum} + {data_ext[SUM_W-1], data_ext};

  // Overflow shows up as disagreement between the two top bits of the wide sum.
  always_comb begin
    sum_next = sum_wide[SUM_W-1:0];
    if (sum_wide[SUM_W] != sum_wide[SUM_W-1])
      sum_next = sum_wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}}
                                 : {1'b0, {(SUM_W-1){1'b1}}};
  end

  assign sum_top = sum[SUM_W-1:DATA_W-1];

  always_comb begin
    sum_sat = sum[DATA_W-1:0];
    if (!(&sum_top || ~|sum_top))
      sum_sat = sum[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                             : {1'b0, {(DATA_W-1){1'b1}}};
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
      min_v <= '0;
      max_v <= '0;
      sum   <= '0;
    end else if (update) begin
      if (first) begin
        count <= CNT_W'(1);
        min_v <= data;
        max_v <= data;
        sum   <= data_ext;
      end else begin
        if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
        if (data < min_v) min_v <= data;
        if (data > max_v) max_v <= data;
        sum <= sum_next;
      end
    end
  end

endmodule

// File: rtl/cubic_frame_reducer.sv
// Reduces each input frame to four summary beats: count, min, max, sum.
// Accepts input while accumulating; emits the summary while input is held off.
module cubic_frame_reducer
  import cubic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  axi_stream_if.slave         in,
  axi_stream_if.master        out
);

  state_t state;
  beat_t  beat;
  logic   first_q;
  logic   in_hs;
  logic   out_hs;
  logic   emit_valid;

  logic        [CNT_W-1:0]  count;
  logic signed [DATA_W-1:0] min_v;
  logic signed [DATA_W-1:0] max_v;
  logic signed [DATA_W-1:0] sum_sat;
  logic        [DATA_W-1:0] beat_data;

  // Gating with rst keeps both handshakes quiet during the reset cycles themselves.
  assign in.tready  = ~rst & (state == ACCUM);
  assign emit_valid = ~rst & (state == EMIT);
  assign in_hs      = in.tvalid & in.tready;
  assign out_hs     = emit_valid & out.tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACCUM;
      beat    <= CNT;
      first_q <= 1'b1;
    end else begin
      case (state)
        ACCUM: if (in_hs) begin
          first_q <= in.tlast;
          if (in.tlast) begin
            state <= EMIT;
            beat  <= CNT;
          end
        end
        EMIT: if (out_hs) begin
          if (beat == SUM) begin
            state <= ACCUM;
            beat  <= CNT;
          end else begin
            beat <= beat_t'(beat + 2'd1);
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  frame_stats_acc #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_stats (
    .clk     (clk),
    .clear   (rst),
    .first   (first_q),
    .update  (in_hs),
    .data    (in.tdata),
    .count   (count),
    .min_v   (min_v),
    .max_v   (max_v),
    .sum_sat (sum_sat)
  );

  // NOTE: default assignment first so no path leaves beat_data unassigned.
  always_comb begin
    beat_data = '0;
    if (emit_valid) begin
      case (beat)
        CNT:     beat_data = DATA_W'(count);
        MIN:     beat_data = min_v;
        MAX:     beat_data = max_v;
        SUM:     beat_data = sum_sat;
        default: beat_data = '0;
      endcase
    end
  end

  assign out.tvalid = emit_valid;
  assign out.tdata  = beat_data;
  assign out.tlast  = emit_valid & (beat == SUM);

endmodule

// File: tb/tb_cubic_frame_reducer.sv
// Bench for cubic_frame_reducer: table vectors, corner sequences and random
// traffic, all checked every cycle against a frame-level reference model.
module tb_cubic_frame_reducer;
  import cubic_pkg::*;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } beat_s;

  typedef struct {
    int          n;
    logic [31:0] d[4];
    logic [31:0] e[4];
  } vec_s;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_stream_if #(.W(32)) in_if ();
  axi_stream_if #(.W(32)) out_if ();

  cubic_frame_reducer #(.DATA_W(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in_if),
    .out (out_if)
  );

  int          total = 0;
  int          bad   = 0;
  beat_s       exp_q[$];
  logic [31:0] frame_q[$];
  beat_s       got_q[$];
  beat_s       pend_q[$];
  vec_s        vecs[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: cycle budget expired", name);
  endtask

  // Frame summary from plain arithmetic over the collected beats.
  function automatic void model_frame();
    longint s = 0;
    int     mn = 0, mx = 0, v, n;
    longint smax = (longint'(1) <<< 47) - 1;
    longint smin = -(longint'(1) <<< 47);
    logic [31:0] sum32;
    beat_s  b;
    foreach (frame_q[i]) begin
      v = frame_q[i];
      if (i == 0) begin mn = v; mx = v; end
      else begin
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
      s = s + longint'(v);
      if (s > smax) s = smax;
      if (s < smin) s = smin;
    end
    n = (frame_q.size() > 65535) ? 65535 : frame_q.size();
    if (s > 64'sd2147483647) sum32 = 32'h7FFF_FFFF;
    else if (s < -64'sd2147483648) sum32 = 32'h8000_0000;
    else sum32 = s[31:0];
    b.l = 1'b0;
    b.d = n;  exp_q.push_back(b);
    b.d = mn; exp_q.push_back(b);
    b.d = mx; exp_q.push_back(b);
    b.d = sum32; b.l = 1'b1; exp_q.push_back(b);
    frame_q.delete();
  endfunction

  // One clock: drive at negedge, check settled outputs, update model, advance.
  task automatic step(input logic v, input logic [31:0] d, input logic l,
                      input logic ordy, output logic took);
    logic  want_v;
    beat_s g;
    in_if.tvalid  = v;
    in_if.tdata   = d;
    in_if.tlast   = l;
    out_if.tready = ordy;
    #1;
    want_v = !rst && (exp_q.size() != 0);
    check("in_tready", in_if.tready, !rst && (exp_q.size() == 0));
    check("out_tvalid", out_if.tvalid, want_v);
    if (want_v) begin
      check("out_tdata", out_if.tdata, exp_q[0].d);
      check("out_tlast", out_if.tlast, exp_q[0].l);
    end else begin
      check("idle_tdata", out_if.tdata, 32'h0);
      check("idle_tlast", out_if.tlast, 1'b0);
    end
    took = v && in_if.tready && !rst;
    if (!rst && out_if.tvalid && ordy) begin
      g.d = out_if.tdata;
      g.l = out_if.tlast;
      got_q.push_back(g);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (took) begin
      frame_q.push_back(d);
      if (l) model_frame();
    end
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      frame_q.delete();
    end
    @(negedge clk);
  endtask

  // Feed pend_q and drain summaries with the given valid/ready percentages.
  task automatic run_stream(input int vpct, input int rpct, input int max_cycles);
    int   cyc = 0;
    logic v, took;
    while ((pend_q.size() != 0 || exp_q.size() != 0) && cyc < max_cycles) begin
      v = (pend_q.size() != 0) && ($urandom_range(99) < vpct);
      step(v, v ? pend_q[0].d : $urandom, v ? pend_q[0].l : 1'b0,
           $urandom_range(99) < rpct, took);
      if (took) void'(pend_q.pop_front());
      cyc++;
    end
    if (cyc >= max_cycles) timeout("stream");
  endtask

  task automatic push_beat(input logic [31:0] d, input logic l);
    beat_s b;
    b.d = d;
    b.l = l;
    pend_q.push_back(b);
  endtask

  task automatic check_summary(input string name, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e[4];
    e = '{e0, e1, e2, e3};
    check({name, "_nbeats"}, got_q.size(), 4);
    if (got_q.size() == 4)
      for (int k = 0; k < 4; k++) begin
        check({name, "_data"}, got_q[k].d, e[k]);
        check({name, "_last"}, got_q[k].l, k == 3);
      end
  endtask

  initial begin
    logic took;
    int   len;

    vecs[0].n = 3; vecs[0].d = '{32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0};
    vecs[0].e = '{32'd3, 32'hFFFF_0000, 32'h0002_0000, 32'h0002_0000};
    vecs[1].n = 1; vecs[1].d = '{5 * Q_ONE, 32'h0, 32'h0, 32'h0};
    vecs[1].e = '{32'd1, 32'h0005_0000, 32'h0005_0000, 32'h0005_0000};
    vecs[2].n = 4; vecs[2].d = '{4{32'h7FFF_FFFF}};
    vecs[2].e = '{32'd4, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vecs[3].n = 4; vecs[3].d = '{4{32'h8000_0000}};
    vecs[3].e = '{32'd4, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[4].n = 2; vecs[4].d = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 32'h0};
    vecs[4].e = '{32'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0};

    rst = 1'b1;
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tlast = 1'b0; out_if.tready = 1'b1;
    @(negedge clk);
    repeat (3) step(1'b1, 32'h1234_5678, 1'b1, 1'b1, took);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b1, took);

    foreach (vecs[i]) begin
      got_q.delete();
      for (int k = 0; k < vecs[i].n; k++) push_beat(vecs[i].d[k], k == vecs[i].n - 1);
      run_stream(100, 100, 200);
      check_summary($sformatf("vec%0d", i), vecs[i].e[0], vecs[i].e[1], vecs[i].e[2], vecs[i].e[3]);
    end

    // Output stalls: before beat 0 and again after beat 0, with input offered.
    got_q.delete();
    step(1'b1, Q_ONE, 1'b0, 1'b1, took);
    step(1'b1, 2 * Q_ONE, 1'b1, 1'b1, took);
    repeat (5) begin
      step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, took);
      check("stall_accept", took, 1'b0);
    end
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, took);
    repeat (5) step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, took);
    run_stream(100, 100, 50);
    check_summary("stall", 32'd2, Q_ONE, 2 * Q_ONE, 3 * Q_ONE);

    // Two frames back to back with input valid every cycle.
    got_q.delete();
    push_beat(32'h0003_0000, 1'b0); push_beat(32'hFFFE_0000, 1'b0); push_beat(32'h0001_8000, 1'b1);
    push_beat(32'h0000_4000, 1'b0); push_beat(32'h0010_0000, 1'b1);
    run_stream(100, 100, 100);
    check("b2b_nbeats", got_q.size(), 8);
    if (got_q.size() == 8) begin
      check("b2b_cnt0", got_q[0].d, 32'd3);
      check("b2b_cnt1", got_q[4].d, 32'd2);
      check("b2b_sum0", got_q[3].d, 32'h0002_8000);
      check("b2b_sum1", got_q[7].d, 32'h0010_4000);
      check("b2b_lasts", {got_q[3].l, got_q[7].l, got_q[2].l, got_q[6].l}, 4'b1100);
    end

    // Reset during the summary, after beat 1 has been taken.
    step(1'b1, 32'h0009_0000, 1'b0, 1'b1, took);
    step(1'b1, 32'hFFF0_0000, 1'b1, 1'b1, took);
    step(1'b0, 32'h0, 1'b0, 1'b1, took);
    step(1'b0, 32'h0, 1'b0, 1'b1, took);
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b1, took);
    rst = 1'b0;
    got_q.delete();
    step(1'b0, 32'h0, 1'b0, 1'b1, took);
    check("post_rst_nbeats", got_q.size(), 0);
    push_beat(3 * Q_ONE, 1'b1);
    run_stream(100, 100, 50);
    check_summary("post_rst", 32'd1, 3 * Q_ONE, 3 * Q_ONE, 3 * Q_ONE);

    // Random frames with random valid/ready gaps.
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++)
        push_beat(($urandom_range(9) == 0) ? {$urandom_range(1), 31'h7FFF_FFF0} : $urandom,
                  k == len - 1);
    end
    run_stream(70, 60, 6000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cubic_frame_reducer.md
CUBIC_FRAME_REDUCER -- requirements
Module: cubic_frame_reducer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the signed Q16.16 sample width of TDATA.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the per-frame beat counter.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port in, axi_stream_if.slave, DATA_W: the cubic pipeline result stream (TDATA/TVALID/TREADY/TLAST).
REQ-006 The block SHALL have port out, axi_stream_if.master, DATA_W: the per-frame summary stream.

Function
REQ-007 A frame SHALL be every accepted input beat up to and including the beat with TLAST=1; a handshake is TVALID&&TREADY in the same cycle.
REQ-008 The FSM SHALL have two states: ACCUM and EMIT; ACCUM→EMIT on the handshake of a TLAST beat; EMIT→ACCUM on the handshake of summary beat 3.
REQ-009 In ACCUM, in.TREADY SHALL be 1 and out.TVALID SHALL be 0; in EMIT, in.TREADY SHALL be 0.
REQ-010 Per accepted beat: count+=1, saturating at 2^CNT_W-1; min/max update by signed compare; sum += sign-extended TDATA in a DATA_W+CNT_W accumulator, saturating at the signed limits of that width.
REQ-011 The first beat of a frame SHALL load min=max=TDATA, count=1 and sum=TDATA, discarding any earlier values.
REQ-012 EMIT SHALL send exactly 4 beats in order: 0 count (zero-extended), 1 min, 2 max, 3 sum saturated to signed DATA_W; TLAST=1 on beat 3 only.
REQ-013 out.TVALID SHALL rise the cycle after the TLAST input handshake (latency 1); on a 1-beat frame, beat 0 SHALL still be count=1.
REQ-014 out.TDATA and out.TLAST SHALL hold stable while TVALID=1 and TREADY=0; the beat index SHALL advance only on an output handshake.
REQ-015 in.TREADY SHALL be 1 in the cycle after the beat-3 handshake, with no dead cycle; back-to-back frames SHALL lose no beats.
REQ-016 out.TDATA SHALL be 0 whenever out.TVALID=0.
REQ-017 Input TVALID with TREADY=0 (in EMIT) SHALL not change any statistic.

Reset
REQ-018 While rst=1: state=ACCUM, beat index=0, count=0, sum=0, min=max=0, in.TREADY=0, out.TVALID=0, out.TDATA=0, out.TLAST=0.
REQ-019 In the first cycle after rst falls, in.TREADY SHALL be 1.
REQ-020 Reset asserted mid-frame or mid-EMIT SHALL drop that frame and its summary without emitting partial beats.

Structure
REQ-021 Package cubic_pkg SHALL hold the state_t enum (ACCUM, EMIT), the summary beat-index enum (CNT, MIN, MAX, SUM), and the Q16.16 constants Q_FRAC=16 and Q_ONE=32'h0001_0000.
REQ-022 Sub-module frame_stats_acc SHALL own the count/min/max/saturating-sum registers, with inputs clear, first and update; the top SHALL own the FSM and the AXI handshakes.

Verification
REQ-023 Frame {0x00010000, 0x00020000, 0xFFFF0000 (TLAST)} with out.TREADY=1 -> out beats 3, 0xFFFF0000, 0x00020000, 0x00020000, TLAST on the 4th, first out.TVALID one cycle after the TLAST handshake.
REQ-024 Single beat 0x00050000 with TLAST -> out beats 1, 0x00050000, 0x00050000, 0x00050000.
REQ-025 Four beats of 0x7FFFFFFF then TLAST, DATA_W=32 -> sum beat 0x7FFFFFFF (saturated), count beat 4.
REQ-026 out.TREADY held at 0 for 5 cycles during EMIT -> TDATA stable, in.TREADY=0, no extra input beats accepted; the beats complete in order after release.
REQ-027 Two frames back to back with in.TVALID=1 continuously -> 8 summary beats, two separate TLAST pulses, no lost input beat.
REQ-028 rst pulsed during EMIT after beat 1 -> out.TVALID=0 the next cycle; the next frame reports only its own values.
